// File: rtl/hazard_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_pkg
//   Shared pipeline types for the ID-stage hazard scoreboard.
//   - reg_idx_t : 4-bit architectural register index
//   - slot_t    : one in-flight writeback record {valid, dest, is_load}
//   - SLOTS     : number of tracked stages after ID (EX, MEM, WB)
// ---------------------------------------------------------------------------
package hazard_scoreboard_pkg;

    localparam int SLOTS = 3;

    typedef logic [3:0] reg_idx_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t dest;
        logic     is_load;
    } slot_t;

endpackage

// File: rtl/hazard_match_slot.sv
// ---------------------------------------------------------------------------
// hazard_match_slot
//   Compares one ID source register against one tracker slot.
//   Ports:
//     src        in  source register number read by ID
//     slot_valid in  slot holds a real register writer
//     slot_dest  in  destination register of that writer
//     match      out slot will write the register ID wants to read
// ---------------------------------------------------------------------------
module hazard_match_slot
    import hazard_scoreboard_pkg::*;
(
    input  reg_idx_t src,
    input  logic     slot_valid,
    input  reg_idx_t slot_dest,
    output logic     match
);

    assign match = slot_valid && (slot_dest == src);

endmodule

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//   Read-after-write hazard detector for the ID stage. A shift tracker follows
//   the register writers sitting in EX (slot0), MEM (slot1) and WB (slot2);
//   ID stalls while any source it uses is still pending in a tracked slot.
//
//   Parameters:
//     SLOTS  number of tracked stages (only 3 is meaningful)
//     CNT_W  width of the saturating stall-cycle counter
//
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     freeze                   memory wait: all tracker state holds
//     flush                    branch taken in EX: ID instruction is squashed
//     id_valid                 ID holds a real instruction
//     id_has_src1, id_src1     first source used / its register
//     id_two_src, id_src2      second source used / its register
//     id_wb_en, id_mem_r_en    ID writes a register / ID is a load
//     id_dest                  ID destination register
//     hazard                   combinational stall request to ID
//     stall_count              saturating count of stalled (unfrozen) cycles
//
//   Build option:
//     HAZARD_SCOREBOARD_FWD_EN  forwarding present: only a load sitting in EX
//                               (load-use) can stall ID.
// ---------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int SLOTS = hazard_scoreboard_pkg::SLOTS,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic             id_valid,
    input  logic             id_has_src1,
    input  logic             id_two_src,
    input  reg_idx_t         id_src1,
    input  reg_idx_t         id_src2,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  reg_idx_t         id_dest,
    output logic             hazard,
    output logic [CNT_W-1:0] stall_count
);

    slot_t            slot_q [SLOTS];
    logic [SLOTS-1:0] match1;
    logic [SLOTS-1:0] match2;
    logic             raw_hazard;
    slot_t            new_entry;

    // One comparator per source per slot.
    for (genvar s = 0; s < SLOTS; s++) begin : g_slot
        hazard_match_slot u_match_src1 (
            .src        (id_src1),
            .slot_valid (slot_q[s].valid),
            .slot_dest  (slot_q[s].dest),
            .match      (match1[s])
        );
        hazard_match_slot u_match_src2 (
            .src        (id_src2),
            .slot_valid (slot_q[s].valid),
            .slot_dest  (slot_q[s].dest),
            .match      (match2[s])
        );
    end

`ifdef HAZARD_SCOREBOARD_FWD_EN
    // Forwarding covers every producer except a load still in EX, whose data
    // only exists after MEM.
    assign raw_hazard = id_valid && slot_q[0].is_load &&
                        ((id_has_src1 && match1[0]) || (id_two_src && match2[0]));

    logic unused_fwd;
    assign unused_fwd = ^{match1[SLOTS-1:1], match2[SLOTS-1:1], slot_q[SLOTS-1].is_load};
`else
    assign raw_hazard = id_valid &&
                        ((id_has_src1 && (|match1)) || (id_two_src && (|match2)));

    // is_load is carried along the tracker but nothing reads it here.
    logic unused_load;
    assign unused_load = slot_q[SLOTS-1].is_load;
`endif

    // A squashed instruction cannot stall anything.
    assign hazard = raw_hazard && !flush;

    // A stalled or squashed instruction enters EX as a bubble.
    always_comb begin
        new_entry         = '0;
        new_entry.valid   = id_valid && id_wb_en && !hazard && !flush;
        new_entry.dest    = id_dest;
        new_entry.is_load = id_mem_r_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                slot_q[i] <= '0;
            end
        end else if (!freeze) begin
            slot_q[0] <= new_entry;
            for (int i = 1; i < SLOTS; i++) begin
                slot_q[i] <= slot_q[i-1];
            end
        end
    end

    // Frozen cycles are not counted: the stall is not what holds ID then.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (hazard && !freeze && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
//   Directed bench for hazard_scoreboard. A reference model keeps the recent
//   register writers by age and derives hazard/stall_count from the rules;
//   every cycle both DUTs are compared to it, and hand-computed literals pin
//   the model at the interesting points. A second instance with a 2-bit
//   counter shares all inputs so counter saturation is reached quickly.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst, freeze, flush;
    logic       id_valid, id_has_src1, id_two_src, id_wb_en, id_mem_r_en;
    logic [3:0] id_src1, id_src2, id_dest;
    logic        hazard, hazard_s;
    logic [15:0] stall_count;
    logic [1:0]  stall_count_s;

    always #5 clk = ~clk;

    hazard_scoreboard #(.SLOTS(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_has_src1(id_has_src1), .id_two_src(id_two_src),
        .id_src1(id_src1), .id_src2(id_src2), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
        .hazard(hazard), .stall_count(stall_count)
    );

    hazard_scoreboard #(.SLOTS(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_has_src1(id_has_src1), .id_two_src(id_two_src),
        .id_src1(id_src1), .id_src2(id_src2), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
        .hazard(hazard_s), .stall_count(stall_count_s)
    );

`ifdef HAZARD_SCOREBOARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // Writers issued on the last three advancing edges, index = age.
    typedef struct packed {
        bit       v;
        bit [3:0] d;
        bit       ld;
    } ent_t;

    ent_t        hist [3];
    int unsigned m_cnt   = 0;
    int unsigned m_cnt_s = 0;
    int          total   = 0;
    int          bad     = 0;

    initial begin
        for (int a = 0; a < 3; a++) hist[a] = '0;
    end

    function automatic bit model_hazard();
        if (!id_valid || flush) return 1'b0;
        for (int a = 0; a < 3; a++) begin
            if (FWD && (a != 0 || !hist[a].ld)) continue;
            if (hist[a].v && ((id_has_src1 && hist[a].d == id_src1) ||
                              (id_two_src  && hist[a].d == id_src2)))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(posedge clk) begin : model
        bit h;
        h = model_hazard();
        if (rst) begin
            for (int a = 0; a < 3; a++) hist[a] <= '0;
            m_cnt   <= 0;
            m_cnt_s <= 0;
        end else if (!freeze) begin
            if (h && m_cnt < 65535) m_cnt <= m_cnt + 1;
            if (h && m_cnt_s < 3)   m_cnt_s <= m_cnt_s + 1;
            hist[2] <= hist[1];
            hist[1] <= hist[0];
            hist[0] <= {id_valid && id_wb_en && !h && !flush, id_dest, id_mem_r_en};
        end
    end

    task automatic chk(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
        end
    endtask

    // Called at a negedge with inputs already driven; checks, then moves to
    // the next negedge. eh/ec < 0 means no literal expectation.
    task automatic tick(input int eh, input int ec);
        #1;
        chk("hazard",          hazard,        model_hazard());
        chk("stall_count",     stall_count,   m_cnt);
        chk("hazard_sat",      hazard_s,      model_hazard());
        chk("stall_count_sat", stall_count_s, m_cnt_s);
        if (eh >= 0) chk("hazard_literal", hazard, eh);
        if (ec >= 0) chk("count_literal", stall_count, ec);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_id(input bit v, input bit h1, input bit [3:0] s1,
                          input bit t2, input bit [3:0] s2,
                          input bit wb, input bit ld, input bit [3:0] d);
        id_valid    = v;
        id_has_src1 = h1;
        id_src1     = s1;
        id_two_src  = t2;
        id_src2     = s2;
        id_wb_en    = wb;
        id_mem_r_en = ld;
        id_dest     = d;
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        tick(0, 0);
        rst = 1'b0;
        // Empty tracker: even a read of R0 through both sources is clean.
        set_id(1, 1, 0, 1, 0, 0, 0, 0);
        tick(0, 0);

`ifdef HAZARD_SCOREBOARD_FWD_EN
        set_id(1, 1, 3, 0, 0, 0, 0, 0);  tick(0, 0);
        set_id(1, 0, 0, 0, 0, 1, 1, 5);  tick(0, 0);   // LDR R5
        set_id(1, 0, 0, 1, 5, 0, 0, 0);  tick(1, 0);   // load-use
        tick(0, 1);
        set_id(1, 0, 0, 0, 0, 1, 0, 5);  tick(0, 1);   // ADD R5
        set_id(1, 0, 0, 1, 5, 0, 0, 0);  tick(0, 1);   // forwarded
        set_id(0, 0, 0, 0, 0, 0, 0, 0);  tick(0, 1);
`else
        // Fresh read of R3 with nothing in flight.
        set_id(1, 1, 3, 0, 0, 0, 0, 0);  tick(0, 0);
        // ADD R2 then a reader of R2: three stall cycles.
        set_id(1, 1, 3, 0, 0, 1, 0, 2);  tick(0, 0);
        set_id(1, 1, 2, 0, 0, 1, 0, 4);
        tick(1, 0); tick(1, 1); tick(1, 2); tick(0, 3);
        set_id(0, 0, 0, 0, 0, 0, 0, 0);  tick(0, 3);

        // Stall on R6 via src2, frozen for 4 cycles in the middle.
        set_id(1, 0, 0, 0, 0, 1, 0, 6);  tick(0, 3);
        set_id(1, 0, 0, 1, 6, 0, 0, 0);  tick(1, 3);
        freeze = 1'b1;
        repeat (4) tick(1, 4);
        freeze = 1'b0;
        tick(1, 4); tick(1, 5); tick(0, 6);
        chk("sat_literal", stall_count_s, 3);

        // Flush masks the hazard and squashes the ID writer (R9).
        set_id(1, 0, 0, 0, 0, 1, 0, 7);  tick(0, 6);
        flush = 1'b1;
        set_id(1, 1, 7, 0, 0, 1, 0, 9);  tick(0, 6);
        flush = 1'b0;
        set_id(1, 1, 9, 0, 0, 0, 0, 0);  tick(0, 6);
        // R7 now in WB: freeze+flush masks, freeze alone holds without counting.
        freeze = 1'b1; flush = 1'b1;
        set_id(1, 1, 7, 0, 0, 0, 0, 0);  tick(0, 6);
        flush = 1'b0;                    tick(1, 6);
        freeze = 1'b0;                   tick(1, 6);
        tick(0, 7);

        // Reset in the middle of a stall, with freeze also high.
        set_id(1, 0, 0, 0, 0, 1, 0, 1);  tick(0, 7);
        set_id(1, 1, 1, 0, 0, 1, 0, 3);  tick(1, 7);
        rst = 1'b1; freeze = 1'b1;       tick(1, 8);
        rst = 1'b0; freeze = 1'b0;       tick(0, 0);
        set_id(0, 0, 0, 0, 0, 0, 0, 0);  tick(0, 0);
`endif

        // Mixed traffic on a small register range so matches are frequent.
        for (int n = 0; n < 80; n++) begin
            freeze = ($urandom_range(0, 4) == 0);
            flush  = ($urandom_range(0, 5) == 0);
            set_id($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)));
            tick(-1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
